// File: rtl/div_pkg.sv
// Shared constants for the sequential divider and its multiplier sibling.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t FIX  = 2'd2;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/div_addsub.sv
// Ripple add/subtract; sub=1 inverts the addend and injects a carry-in of one.
module div_addsub
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] bx;
  logic             cy;

  always_comb begin
    bx  = b ^ {WIDTH{sub}};
    sum = '0;
    cy  = sub;
    // Carry out of the top bit is dropped.
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ bx[i] ^ cy;
      cy     = (a[i] & bx[i]) | (cy & (a[i] ^ bx[i]));
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned non-restoring divider: WIDTH shift/add-sub steps, then a remainder fix-up.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   op_a;
  logic             op_sub;
  logic [WIDTH:0]   as_sum;

  assign a_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  // FIX reuses the chain to add M back onto a negative remainder.
  assign op_a   = (state_q == FIX) ? a_q : a_sh;
  assign op_sub = (state_q == RUN) & ~a_q[WIDTH];

  div_addsub #(
    .WIDTH(WIDTH + 1)
  ) u_addsub (
    .a  (op_a),
    .b  ({1'b0, m_q}),
    .sub(op_sub),
    .sum(as_sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            state_d = RUN;
            a_d     = '0;
            q_d     = dividend;
            m_d     = divisor;
            count_d = CW'(WIDTH - 1);
            busy_d  = 1'b1;
          end else begin
            quot_d = '1;
            rem_d  = dividend;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        a_d     = as_sum;
        q_d     = {q_q[WIDTH-2:0], ~as_sum[WIDTH]};
        count_d = count_q - CW'(1);
        if (count_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        a_d     = a_q[WIDTH] ? as_sum : a_q;
        quot_d  = q_q;
        rem_d   = a_d[WIDTH-1:0];
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and sweep checks of seq_divider at WIDTH=4 and WIDTH=8.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] dividend, divisor, quotient, remainder;
  logic       busy, done, div_by_zero;

  logic       start8;
  logic [7:0] dividend8, divisor8, quotient8, remainder8;
  logic       busy8, done8, dbz8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .start      (start8),
    .dividend   (dividend8),
    .divisor    (divisor8),
    .busy       (busy8),
    .done       (done8),
    .quotient   (quotient8),
    .remainder  (remainder8),
    .div_by_zero(dbz8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge; start is seen by the next rising edge.
  // lat = falling edges after the accepting edge until done is seen.
  task automatic run4(input logic [3:0] dd, input logic [3:0] dv, input bit repulse,
                      output logic [3:0] q, output logic [3:0] r, output logic z,
                      output int lat, output int nbusy);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (repulse && (lat == 1 || lat == 3)) begin
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (lat >= 40) check("done_timeout", done, 1);
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic run8(input logic [7:0] dd, input logic [7:0] dv,
                      output logic [7:0] q, output logic [7:0] r, output int lat);
    start8    = 1'b1;
    dividend8 = dd;
    divisor8  = dv;
    @(negedge clk);
    start8 = 1'b0;
    lat    = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) check("done8_timeout", done8, 1);
    q = quotient8;
    r = remainder8;
  endtask

  initial begin
    logic [3:0] q, r;
    logic       z;
    logic [7:0] q8, r8, a8, b8;
    int         lat, lat2, nb, extra;

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    // 13 / 3
    run4(4'd13, 4'd3, 1'b0, q, r, z, lat, nb);
    check("13/3_lat", lat, 5);
    check("13/3_busy", nb, 5);
    check("13/3_busy_at_done", busy, 0);
    check("13/3_q", q, 4);
    check("13/3_r", r, 1);
    check("13/3_dbz", z, 0);
    @(negedge clk);
    check("13/3_done_pulse", done, 0);
    check("13/3_q_hold", quotient, 4);

    // 15 / 1 then 2 / 9 started in the done cycle
    @(negedge clk);
    run4(4'd15, 4'd1, 1'b0, q, r, z, lat, nb);
    check("15/1_q", q, 15);
    check("15/1_r", r, 0);
    run4(4'd2, 4'd9, 1'b0, q, r, z, lat2, nb);
    check("2/9_q", q, 0);
    check("2/9_r", r, 2);
    check("b2b_gap", 1 + lat2, 6);

    // 7 / 0 then 0 / 5
    @(negedge clk);
    run4(4'd7, 4'd0, 1'b0, q, r, z, lat, nb);
    check("7/0_lat", lat, 0);
    check("7/0_busy", nb + busy, 0);
    check("7/0_q", q, 15);
    check("7/0_r", r, 7);
    check("7/0_dbz", z, 1);
    @(negedge clk);
    check("7/0_done_pulse", done, 0);
    check("7/0_dbz_hold", div_by_zero, 1);
    run4(4'd0, 4'd5, 1'b0, q, r, z, lat, nb);
    check("0/5_q", q, 0);
    check("0/5_r", r, 0);
    check("0/5_dbz", z, 0);

    // 14 / 4 with starts during busy
    @(negedge clk);
    run4(4'd14, 4'd4, 1'b1, q, r, z, lat, nb);
    check("14/4_lat", lat, 5);
    check("14/4_q", q, 3);
    check("14/4_r", r, 2);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("14/4_extra_done", extra, 0);
    check("14/4_q_hold", quotient, 3);

    // async reset mid-run of 11 / 2
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("arst_no_done", extra, 0);
    run4(4'd11, 4'd2, 1'b0, q, r, z, lat, nb);
    check("11/2_q", q, 5);
    check("11/2_r", r, 1);

    // full WIDTH=4 sweep
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        @(negedge clk);
        run4(4'(dd), 4'(dv), 1'b0, q, r, z, lat, nb);
        if (dv == 0) begin
          check("sweep0_q", q, 15);
          check("sweep0_r", r, dd);
          check("sweep0_dbz", z, 1);
        end else begin
          check("sweep_q", q, dd / dv);
          check("sweep_r", r, dd % dv);
          check("sweep_dbz", z, 0);
        end
      end
    end

    // WIDTH=8 random pairs
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(1, 255));
      @(negedge clk);
      run8(a8, b8, q8, r8, lat);
      if (i == 0) check("w8_lat", lat, 9);
      check("w8_q", q8, a8 / b8);
      check("w8_r", r8, a8 % b8);
      check("w8_dbz", dbz8, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
